// File: rtl/conv3x3_stream_pkg.sv
// Shared constants, types and arithmetic helpers for the 3x3 streaming convolution engine.
package conv_pkg;

  localparam int unsigned K           = 3;
  localparam int unsigned NUM_TAPS    = K * K;
  localparam int unsigned COEF_ADDR_W = 4;
  localparam int unsigned TAP_CENTER  = 4;
  localparam logic [COEF_ADDR_W-1:0] LAST_TAP = COEF_ADDR_W'(NUM_TAPS - 1);

  typedef enum logic {
    FR_IDLE,
    FR_BUSY
  } frame_state_e;

  // Wide enough that nine full-scale products cannot overflow.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned coef_w);
    return data_w + coef_w + 5;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] acc,
                                                  input int unsigned     out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/conv3x3_stream_if.sv
// Pixel, coefficient and result signals of the convolution engine.
interface conv3x3_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 16
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     coef_we;
  logic [3:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     frame_done;
  logic                     busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  out_valid, out_data, frame_done, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output out_valid, out_data, frame_done, busy
  );
endinterface

// File: rtl/conv3x3_stream_line_buffer.sv
// Enabled shift register delaying a pixel stream by DEPTH accepted samples.
module line_buffer #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en_i) begin
      mem_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q_o = mem_q[DEPTH-1];
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming valid-mode 3x3 convolution with double-buffered runtime kernel and
// registered, shifted and saturated output.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 5,
  parameter int unsigned IMG_H  = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0
) (
  input logic             clk,
  input logic             reset,
  conv3x3_stream_if.slave bus
);
  localparam int unsigned ACC_W = acc_w(DATA_W, COEF_W);
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  frame_state_e  state_q, state_d;
  logic          accept, first_px, last_px, interior;

  logic [DATA_W-1:0]        lb1_out, lb0_out;
  logic [DATA_W-1:0]        win_q [K][K-1];
  logic [DATA_W-1:0]        tap   [K][K];
  logic signed [COEF_W-1:0] shadow_q [NUM_TAPS];
  logic signed [COEF_W-1:0] active_q [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc, px_ext, cf_ext, acc_sh;
  logic signed [63:0]       sat;

  logic                    out_valid_q, frame_done_q;
  logic signed [OUT_W-1:0] out_data_q;

  assign accept   = bus.in_valid;
  assign first_px = (row_q == '0) && (col_q == '0);
  assign last_px  = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign interior = (row_q >= ROW_MIN) && (col_q >= COL_MIN);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    state_d = state_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (first_px)     state_d = FR_BUSY;
      else if (last_px) state_d = FR_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= FR_IDLE;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
    end
  end

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk(clk), .reset(reset), .en_i(accept), .d_i(bus.in_data), .q_o(lb1_out)
  );
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk(clk), .reset(reset), .en_i(accept), .d_i(lb1_out), .q_o(lb0_out)
  );

  // Only the two older window columns are registered; the newest column is the
  // live line-buffer outputs plus the incoming pixel, giving single-cycle latency.
  always_comb begin
    for (int unsigned i = 0; i < K; i++) begin
      tap[i][0] = win_q[i][0];
      tap[i][1] = win_q[i][1];
    end
    tap[0][2] = lb0_out;
    tap[1][2] = lb1_out;
    tap[2][2] = bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < K; i++) begin
        win_q[i][0] <= '0;
        win_q[i][1] <= '0;
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < K; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= tap[i][2];
      end
    end
  end

  // The active bank copies the pre-write shadow, so a write coincident with (0,0)
  // lands in shadow only and first takes effect one frame later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= (k == TAP_CENTER) ? COEF_W'(1) : '0;
        active_q[k] <= (k == TAP_CENTER) ? COEF_W'(1) : '0;
      end
    end else begin
      if (bus.coef_we && (bus.coef_addr <= LAST_TAP)) shadow_q[bus.coef_addr] <= bus.coef_data;
      if (accept && first_px) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  always_comb begin
    acc    = '0;
    px_ext = '0;
    cf_ext = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        px_ext = {{(ACC_W-DATA_W){1'b0}}, tap[i][j]};
        cf_ext = {{(ACC_W-COEF_W){active_q[K*i+j][COEF_W-1]}}, active_q[K*i+j]};
        acc    = acc + px_ext * cf_ext;
      end
    end
    acc_sh = acc >>> SHIFT;
    sat    = saturate(64'(acc_sh), OUT_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= accept && interior;
      frame_done_q <= accept && last_px;
      if (accept && interior) out_data_q <= sat[OUT_W-1:0];
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == FR_BUSY);
endmodule
